// File: rtl/frame_capture_fifo.sv
// frame_capture_fifo
//   Single-clock camera frame grabber. A Start pulse arms the block, which then
//   waits for the next frame start (FVAL rise). It packs qualified pixels into
//   32-bit words and buffers them in a DEPTH-word FIFO that the host drains.
//   Optional build macro: CAPTURE_TEST_PATTERN_EN replaces each accepted pixel
//   value with an 8-bit wrapping counter that restarts at every FVAL rise.
module frame_capture_fifo #(
   parameter int DATA_W      = 10,
   parameter int PIXEL_W     = 8,
   parameter int DEPTH       = 1024,
   parameter int BLOCK_WORDS = 256
) (
   input  logic                     FSM_Clk,
   input  logic                     FSM_Rst_n,
   input  logic                     Start,
   input  logic                     Abort,
   input  logic [DATA_W-1:0]        Data,
   input  logic                     FVAL,
   input  logic                     LVAL,
   input  logic                     DVAL,
   input  logic                     Rd_En,
   output logic [31:0]              Rd_Data,
   output logic                     Rd_Valid,
   output logic                     Empty,
   output logic                     Full,
   output logic                     Block_Full,
   output logic [$clog2(DEPTH):0]   Level,
   output logic                     Frame_Done,
   output logic                     Overflow,
   output logic [2:0]               State
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int N  = 32 / PIXEL_W;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARM     = 3'd1,
      ST_WAIT    = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_FLUSH   = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

   state_t            state_reg, state_next;
   logic              fval_prev_reg;
   logic              fval_rise, fval_fall;
   logic              capture_window, flush_window;
   logic              pix_accept, flush_write, done_set;

   logic [PIXEL_W-1:0] sensor_pixel, pixel_value;
   logic [31:0]        pack_reg, pack_merged;
   logic [CW-1:0]      lane_reg;
   logic               last_lane;

   logic               wr_req, wr_fire, rd_fire;
   logic [31:0]        wr_word;
   logic [AW-1:0]      wr_ptr_reg, rd_ptr_reg;
   logic [LW-1:0]      level_reg, level_next;
   logic               empty_reg, full_reg, block_full_reg;
   logic               overflow_reg, frame_done_reg, rd_valid_reg;
   logic [31:0]        rd_word_reg;
   logic [31:0]        mem [DEPTH];
   logic               unused_bits;

   assign fval_rise = FVAL & ~fval_prev_reg;
   assign fval_fall = ~FVAL & fval_prev_reg;

   // State register plus the FVAL history used for edge detection
   always_ff @(posedge FSM_Clk or negedge FSM_Rst_n) begin
      if (!FSM_Rst_n) begin
         state_reg     <= ST_IDLE;
         fval_prev_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         fval_prev_reg <= FVAL;
      end
   end

   // Next-state logic; Start has priority over Abort
   always_comb begin
      state_next = state_reg;
      if (Start) begin
         state_next = ST_ARM;
      end else if (Abort) begin
         state_next = ST_IDLE;
      end else begin
         case (state_reg)
            ST_ARM:     if (!FVAL)     state_next = ST_WAIT;
            ST_WAIT:    if (fval_rise) state_next = ST_CAPTURE;
            ST_CAPTURE: if (fval_fall) state_next = ST_FLUSH;
            ST_FLUSH:                  state_next = ST_DONE;
            default:                   state_next = state_reg;
         endcase
      end
   end

   // State-derived controls; the FVAL-rise cycle in WAIT already captures
   always_comb begin
      capture_window = 1'b0;
      flush_window   = 1'b0;
      case (state_reg)
         ST_WAIT:    capture_window = fval_rise;
         ST_CAPTURE: capture_window = 1'b1;
         ST_FLUSH:   flush_window   = 1'b1;
         default:    ;
      endcase
      pix_accept  = capture_window & FVAL & LVAL & DVAL & ~Start & ~Abort;
      flush_write = flush_window & (lane_reg != '0) & ~Start & ~Abort;
      done_set    = flush_window & ~Start & ~Abort;
   end

   // Pixel field: top PIXEL_W bits of the bus, zero-extended for wide pixels
   generate
      if (PIXEL_W <= DATA_W) begin : g_pix_slice
         assign sensor_pixel = Data[DATA_W-1 -: PIXEL_W];
      end else begin : g_pix_ext
         assign sensor_pixel = PIXEL_W'(Data);
      end
   endgenerate

`ifdef CAPTURE_TEST_PATTERN_EN
   logic [7:0] pattern_reg, pattern_value;
   assign pattern_value = fval_rise ? 8'd0 : pattern_reg;
   assign pixel_value   = PIXEL_W'(pattern_value);

   // Test-pattern counter: restarts at each frame start, advances per accepted pixel
   always_ff @(posedge FSM_Clk or negedge FSM_Rst_n) begin
      if (!FSM_Rst_n)      pattern_reg <= 8'd0;
      else if (pix_accept) pattern_reg <= pattern_value + 8'd1;
      else if (fval_rise)  pattern_reg <= 8'd0;
   end
`else
   assign pixel_value = sensor_pixel;
`endif

   // Low data bits below the pixel field are intentionally ignored
   assign unused_bits = ^{Data, sensor_pixel};

   // Merge the incoming pixel into its lane; lane 0 holds the first pixel
   always_comb begin
      pack_merged = pack_reg;
      pack_merged[lane_reg*PIXEL_W +: PIXEL_W] = pixel_value;
   end

   assign last_lane = (lane_reg == CW'(N - 1));
   assign wr_req    = (pix_accept & last_lane) | flush_write;
   assign wr_word   = flush_write ? pack_reg : pack_merged;
   assign wr_fire   = wr_req & ~full_reg;
   assign rd_fire   = Rd_En & ~empty_reg & ~Start;

   // Packer: accumulates pixels; cleared on Start/Abort, full word, or flush
   always_ff @(posedge FSM_Clk or negedge FSM_Rst_n) begin
      if (!FSM_Rst_n) begin
         pack_reg <= '0;
         lane_reg <= '0;
      end else if (Start || Abort) begin
         pack_reg <= '0;
         lane_reg <= '0;
      end else if (pix_accept) begin
         if (last_lane) begin
            pack_reg <= '0;
            lane_reg <= '0;
         end else begin
            pack_reg <= pack_merged;
            lane_reg <= lane_reg + CW'(1);
         end
      end else if (flush_window) begin
         pack_reg <= '0;
         lane_reg <= '0;
      end
   end

   // Occupancy after this cycle's accepted push/pop
   always_comb begin
      level_next = level_reg;
      case ({wr_fire, rd_fire})
         2'b10:   level_next = level_reg + LW'(1);
         2'b01:   level_next = level_reg - LW'(1);
         default: level_next = level_reg;
      endcase
   end

   // FIFO bookkeeping and sticky status flags
   always_ff @(posedge FSM_Clk or negedge FSM_Rst_n) begin
      if (!FSM_Rst_n) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         level_reg      <= '0;
         empty_reg      <= 1'b1;
         full_reg       <= 1'b0;
         block_full_reg <= 1'b0;
         overflow_reg   <= 1'b0;
         frame_done_reg <= 1'b0;
         rd_valid_reg   <= 1'b0;
      end else if (Start) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         level_reg      <= '0;
         empty_reg      <= 1'b1;
         full_reg       <= 1'b0;
         block_full_reg <= 1'b0;
         overflow_reg   <= 1'b0;
         frame_done_reg <= 1'b0;
         rd_valid_reg   <= 1'b0;
      end else begin
         if (wr_fire) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (rd_fire) rd_ptr_reg <= rd_ptr_reg + AW'(1);
         level_reg      <= level_next;
         empty_reg      <= (level_next == '0);
         full_reg       <= (level_next == LW'(DEPTH));
         block_full_reg <= (level_next >= LW'(BLOCK_WORDS));
         if (wr_req && full_reg) overflow_reg <= 1'b1;
         if (done_set) frame_done_reg <= 1'b1;
         rd_valid_reg   <= rd_fire;
      end
   end

   // Word storage (no reset so it maps onto block RAM)
   always_ff @(posedge FSM_Clk) begin
      if (wr_fire) mem[wr_ptr_reg] <= wr_word;
   end

   // Registered RAM read
   always_ff @(posedge FSM_Clk) begin
      if (rd_fire) rd_word_reg <= mem[rd_ptr_reg];
   end

   assign Rd_Data    = rd_valid_reg ? rd_word_reg : 32'd0;
   assign Rd_Valid   = rd_valid_reg;
   assign Empty      = empty_reg;
   assign Full       = full_reg;
   assign Block_Full = block_full_reg;
   assign Level      = level_reg;
   assign Frame_Done = frame_done_reg;
   assign Overflow   = overflow_reg;
   assign State      = state_reg;

endmodule

// File: tb/tb_frame_capture_fifo.sv
// Directed bench for frame_capture_fifo. Two instances share stimulus:
// dut_a (DEPTH=16, BLOCK_WORDS=8) and dut_b (DEPTH=4, BLOCK_WORDS=2).
module tb_frame_capture_fifo;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, abort = 1'b0;
   logic [9:0]  data = '0;
   logic        fval = 1'b0, lval = 1'b0, dval = 1'b0;
   logic        rd_en = 1'b0;

   logic [31:0] a_rd_data, b_rd_data;
   logic        a_rd_valid, a_empty, a_full, a_block_full, a_frame_done, a_overflow;
   logic        b_rd_valid, b_empty, b_full, b_block_full, b_frame_done, b_overflow;
   logic [4:0]  a_level;
   logic [2:0]  b_level;
   logic [2:0]  a_state, b_state;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_word;

   always #5 clk = ~clk;

   frame_capture_fifo #(.DATA_W(10), .PIXEL_W(8), .DEPTH(16), .BLOCK_WORDS(8)) dut_a (
      .FSM_Clk(clk), .FSM_Rst_n(rst_n), .Start(start), .Abort(abort), .Data(data),
      .FVAL(fval), .LVAL(lval), .DVAL(dval), .Rd_En(rd_en),
      .Rd_Data(a_rd_data), .Rd_Valid(a_rd_valid), .Empty(a_empty), .Full(a_full),
      .Block_Full(a_block_full), .Level(a_level), .Frame_Done(a_frame_done),
      .Overflow(a_overflow), .State(a_state));

   frame_capture_fifo #(.DATA_W(10), .PIXEL_W(8), .DEPTH(4), .BLOCK_WORDS(2)) dut_b (
      .FSM_Clk(clk), .FSM_Rst_n(rst_n), .Start(start), .Abort(abort), .Data(data),
      .FVAL(fval), .LVAL(lval), .DVAL(dval), .Rd_En(rd_en),
      .Rd_Data(b_rd_data), .Rd_Valid(b_rd_valid), .Empty(b_empty), .Full(b_full),
      .Block_Full(b_block_full), .Level(b_level), .Frame_Done(b_frame_done),
      .Overflow(b_overflow), .State(b_state));

   // Inputs change right after a falling edge; outputs are sampled at the next one
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      start = 1'b0; abort = 1'b0; fval = 1'b0; lval = 1'b0; dval = 1'b0; rd_en = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1; cyc(); start = 1'b0;
   endtask

   task automatic drive_pixel(input int k);
      fval = 1'b1; lval = 1'b1; dval = 1'b1; data = 10'(k * 4); cyc();
   endtask

   task automatic frame_lead_in();
      pulse_start();
      fval = 1'b0; cyc(); cyc(); cyc();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; idle_inputs(); cyc(); cyc();
      checks++; if (a_state !== 3'd0 || a_empty !== 1'b1 || a_full !== 1'b0 || a_level !== 5'd0)
         begin failures++; $display("FAIL reset_a: state=%0d empty=%b full=%b level=%0d required 0/1/0/0", a_state, a_empty, a_full, a_level); end
      checks++; if (a_rd_valid !== 1'b0 || a_rd_data !== 32'd0 || a_frame_done !== 1'b0 || a_overflow !== 1'b0 || a_block_full !== 1'b0)
         begin failures++; $display("FAIL reset_a_flags: rv=%b rd=%h fd=%b ov=%b bf=%b required all 0", a_rd_valid, a_rd_data, a_frame_done, a_overflow, a_block_full); end
      rst_n = 1'b1; cyc();
      $display("reset released");
   endtask

   task automatic test_frame8();
      pulse_start();
      checks++; if (a_state !== 3'd1) begin failures++; $display("FAIL frame8_arm: state=%0d required 1", a_state); end
      fval = 1'b0; cyc(); cyc(); cyc();
      checks++; if (a_state !== 3'd2) begin failures++; $display("FAIL frame8_wait: state=%0d required 2", a_state); end
      for (int k = 1; k <= 8; k++) drive_pixel(k);
      idle_inputs(); cyc();
      checks++; if (a_state !== 3'd4) begin failures++; $display("FAIL frame8_flush: state=%0d required 4", a_state); end
      cyc();
      checks++; if (a_state !== 3'd5 || a_frame_done !== 1'b1 || a_level !== 5'd2)
         begin failures++; $display("FAIL frame8_done: state=%0d fd=%b level=%0d required 5/1/2", a_state, a_frame_done, a_level); end
      rd_en = 1'b1; cyc();
      $display("read a word1=%h valid=%b", a_rd_data, a_rd_valid);
      checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 32'h04030201)
         begin failures++; $display("FAIL frame8_word1: data=%h valid=%b required 04030201/1", a_rd_data, a_rd_valid); end
      cyc();
      $display("read a word2=%h valid=%b", a_rd_data, a_rd_valid);
      checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 32'h08070605)
         begin failures++; $display("FAIL frame8_word2: data=%h valid=%b required 08070605/1", a_rd_data, a_rd_valid); end
      cyc();
      checks++; if (a_rd_valid !== 1'b0 || a_empty !== 1'b1)
         begin failures++; $display("FAIL frame8_empty_read: valid=%b empty=%b required 0/1", a_rd_valid, a_empty); end
      rd_en = 1'b0;
   endtask

   task automatic test_flush6();
      frame_lead_in();
      for (int k = 1; k <= 6; k++) drive_pixel(k);
      idle_inputs(); cyc(); cyc();
      checks++; if (a_level !== 5'd2 || a_state !== 3'd5)
         begin failures++; $display("FAIL flush6_level: level=%0d state=%0d required 2/5", a_level, a_state); end
      rd_en = 1'b1; cyc(); cyc(); rd_en = 1'b0;
      $display("read a flush word=%h valid=%b", a_rd_data, a_rd_valid);
      checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 32'h00000605)
         begin failures++; $display("FAIL flush6_word: data=%h valid=%b required 00000605/1", a_rd_data, a_rd_valid); end
   endtask

   task automatic test_overflow();
      frame_lead_in();
      for (int k = 1; k <= 24; k++) drive_pixel(k);
      idle_inputs(); cyc(); cyc();
      checks++; if (b_full !== 1'b1 || b_overflow !== 1'b1 || b_level !== 3'd4)
         begin failures++; $display("FAIL overflow_b: full=%b ov=%b level=%0d required 1/1/4", b_full, b_overflow, b_level); end
      checks++; if (a_overflow !== 1'b0 || a_level !== 5'd6)
         begin failures++; $display("FAIL overflow_a: ov=%b level=%0d required 0/6", a_overflow, a_level); end
      rd_en = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         cyc();
         exp_word = {8'(4*k), 8'(4*k-1), 8'(4*k-2), 8'(4*k-3)};
         $display("read b word%0d=%h valid=%b", k, b_rd_data, b_rd_valid);
         checks++; if (b_rd_valid !== 1'b1 || b_rd_data !== exp_word)
            begin failures++; $display("FAIL overflow_read%0d: data=%h valid=%b required %h/1", k, b_rd_data, b_rd_valid, exp_word); end
         if (k == 1) begin
            checks++; if (b_full !== 1'b0 || b_level !== 3'd3)
               begin failures++; $display("FAIL overflow_pop: full=%b level=%0d required 0/3", b_full, b_level); end
         end
      end
      rd_en = 1'b0; cyc();
      checks++; if (b_empty !== 1'b1 || b_overflow !== 1'b1)
         begin failures++; $display("FAIL overflow_drained: empty=%b ov=%b required 1/1", b_empty, b_overflow); end
   endtask

   task automatic test_block_full();
      pulse_start();
      checks++; if (b_overflow !== 1'b0 || b_level !== 3'd0 || b_frame_done !== 1'b0)
         begin failures++; $display("FAIL start_clear: ov=%b level=%0d fd=%b required 0/0/0", b_overflow, b_level, b_frame_done); end
      fval = 1'b0; cyc(); cyc(); cyc();
      for (int k = 1; k <= 8; k++) begin
         drive_pixel(k);
         if (k == 4) begin
            checks++; if (b_level !== 3'd1 || b_block_full !== 1'b0)
               begin failures++; $display("FAIL block_below: level=%0d bf=%b required 1/0", b_level, b_block_full); end
         end
         if (k == 8) begin
            checks++; if (b_level !== 3'd2 || b_block_full !== 1'b1)
               begin failures++; $display("FAIL block_hit: level=%0d bf=%b required 2/1", b_level, b_block_full); end
         end
      end
      idle_inputs(); cyc();
      rd_en = 1'b1; cyc(); rd_en = 1'b0;
      checks++; if (b_level !== 3'd1 || b_block_full !== 1'b0)
         begin failures++; $display("FAIL block_fall: level=%0d bf=%b required 1/0", b_level, b_block_full); end
   endtask

   task automatic test_start_in_wait();
      pulse_start(); cyc();
      checks++; if (a_state !== 3'd2) begin failures++; $display("FAIL siw_wait: state=%0d required 2", a_state); end
      start = 1'b1; drive_pixel(9); start = 1'b0;
      checks++; if (a_state !== 3'd1 || a_level !== 5'd0)
         begin failures++; $display("FAIL siw_rearm: state=%0d level=%0d required 1/0", a_state, a_level); end
      for (int k = 10; k <= 13; k++) drive_pixel(k);
      checks++; if (a_state !== 3'd1 || a_level !== 5'd0)
         begin failures++; $display("FAIL siw_midframe: state=%0d level=%0d required 1/0", a_state, a_level); end
      idle_inputs(); cyc();
      checks++; if (a_state !== 3'd2) begin failures++; $display("FAIL siw_wait2: state=%0d required 2", a_state); end
      for (int k = 1; k <= 4; k++) drive_pixel(k);
      idle_inputs(); cyc(); cyc();
      checks++; if (a_state !== 3'd5 || a_level !== 5'd1)
         begin failures++; $display("FAIL siw_done: state=%0d level=%0d required 5/1", a_state, a_level); end
      rd_en = 1'b1; cyc(); rd_en = 1'b0;
      $display("read a siw word=%h valid=%b", a_rd_data, a_rd_valid);
      checks++; if (a_rd_valid !== 1'b1 || a_rd_data !== 32'h04030201)
         begin failures++; $display("FAIL siw_word: data=%h valid=%b required 04030201/1", a_rd_data, a_rd_valid); end
   endtask

   task automatic test_abort();
      frame_lead_in();
      for (int k = 1; k <= 6; k++) drive_pixel(k);
      abort = 1'b1; drive_pixel(7); abort = 1'b0;
      checks++; if (a_state !== 3'd0 || a_level !== 5'd1)
         begin failures++; $display("FAIL abort_idle: state=%0d level=%0d required 0/1", a_state, a_level); end
      idle_inputs(); cyc(); cyc();
      checks++; if (a_level !== 5'd1 || a_frame_done !== 1'b0 || a_state !== 3'd0)
         begin failures++; $display("FAIL abort_noflush: level=%0d fd=%b state=%0d required 1/0/0", a_level, a_frame_done, a_state); end
   endtask

   task automatic test_reset_mid();
      frame_lead_in();
      for (int k = 1; k <= 20; k++) drive_pixel(k);
      checks++; if (a_level !== 5'd5 || a_state !== 3'd3)
         begin failures++; $display("FAIL midreset_pre: level=%0d state=%0d required 5/3", a_level, a_state); end
      rst_n = 1'b0; cyc();
      checks++; if (a_state !== 3'd0 || a_level !== 5'd0 || a_empty !== 1'b1 || a_rd_valid !== 1'b0 || a_rd_data !== 32'd0)
         begin failures++; $display("FAIL midreset_a: state=%0d level=%0d empty=%b rv=%b rd=%h required 0/0/1/0/0", a_state, a_level, a_empty, a_rd_valid, a_rd_data); end
      checks++; if (b_full !== 1'b0 || b_overflow !== 1'b0 || b_block_full !== 1'b0 || b_level !== 3'd0 || b_frame_done !== 1'b0)
         begin failures++; $display("FAIL midreset_b: full=%b ov=%b bf=%b level=%0d fd=%b required 0/0/0/0/0", b_full, b_overflow, b_block_full, b_level, b_frame_done); end
      idle_inputs(); rst_n = 1'b1; cyc();
      $display("mid-capture reset released");
   endtask

   initial begin
      test_reset();
      test_frame8();
      test_flush6();
      test_overflow();
      test_block_full();
      test_start_in_wait();
      test_abort();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
